// File: rtl/count_game_ctrl.sv
// Two-button countdown controller: counts START_VAL down to 0, one step per CLK_HZ cycles.
// Define DEBOUNCE_EN to require DB_CYCLES stable samples before a button level is accepted.
module count_game_ctrl #(
  parameter int CLK_HZ    = 1000,
  parameter int DB_CYCLES = 20,
  parameter int START_VAL = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_start,
  input  logic       btn_pause,
  output logic [2:0] num,
  output logic       running,
  output logic       done,
  output logic       tick
);
  localparam int SEC_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [SEC_W-1:0] SEC_LAST = SEC_W'(CLK_HZ - 1);
  localparam logic [2:0] NUM_INIT = 3'(START_VAL);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

  state_t           state_reg;
  logic [SEC_W-1:0] sec_cnt_reg;
  logic [1:0]       btn_raw;
  logic [1:0]       press;
  logic [1:0]       vld_reg;
  logic             start_p;
  logic             pause_p;

  assign btn_raw = {btn_pause, btn_start};
  assign start_p = press[0];
  assign pause_p = press[1];

  // vld_reg[1] marks when the synchroniser output reflects real post-reset samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_reg <= '0;
    else        vld_reg <= {vld_reg[0], 1'b1};
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_btn
    logic [1:0] sync_reg;
    logic       filt;
    logic       filt_prev_reg;
    logic       armed_reg;
    logic       press_reg;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sync_reg <= '0;
      else        sync_reg <= {sync_reg[0], btn_raw[gi]};
    end

`ifdef DEBOUNCE_EN
    localparam int DB_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    logic [DB_W-1:0] db_cnt_reg;
    logic            db_lvl_reg;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        db_cnt_reg <= '0;
        db_lvl_reg <= 1'b0;
      end else if (sync_reg[1] == db_lvl_reg) begin
        db_cnt_reg <= '0;
      end else if (db_cnt_reg == DB_W'(DB_CYCLES - 1)) begin
        db_lvl_reg <= sync_reg[1];
        db_cnt_reg <= '0;
      end else begin
        db_cnt_reg <= db_cnt_reg + 1'b1;
      end
    end
    assign filt = db_lvl_reg;
`else
    localparam int unused_db_cycles = DB_CYCLES;
    assign filt = sync_reg[1];
`endif

    // A button held through reset must be seen released before its next press counts.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        filt_prev_reg <= 1'b0;
        armed_reg     <= 1'b0;
        press_reg     <= 1'b0;
      end else begin
        filt_prev_reg <= filt;
        armed_reg     <= armed_reg | (vld_reg[1] & ~sync_reg[1]);
        press_reg     <= armed_reg & filt & ~filt_prev_reg;
      end
    end
    assign press[gi] = press_reg;
  end

  // Start outranks pause and the second-wrap in every state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      num         <= NUM_INIT;
      running     <= 1'b0;
      done        <= 1'b0;
      tick        <= 1'b0;
      sec_cnt_reg <= '0;
    end else begin
      tick <= 1'b0;
      if (start_p) begin
        sec_cnt_reg <= '0;
        if (START_VAL == 0) begin
          state_reg <= DONE;
          num       <= 3'd0;
          running   <= 1'b0;
          done      <= 1'b1;
        end else begin
          state_reg <= RUN;
          num       <= NUM_INIT;
          running   <= 1'b1;
          done      <= 1'b0;
        end
      end else begin
        case (state_reg)
          RUN: begin
            if (pause_p) begin
              state_reg <= PAUSE;
              running   <= 1'b0;
            end else if (sec_cnt_reg == SEC_LAST) begin
              sec_cnt_reg <= '0;
              tick        <= 1'b1;
              if (num <= 3'd1) begin
                num       <= 3'd0;
                state_reg <= DONE;
                running   <= 1'b0;
                done      <= 1'b1;
              end else begin
                num <= num - 3'd1;
              end
            end else begin
              sec_cnt_reg <= sec_cnt_reg + 1'b1;
            end
          end
          PAUSE: begin
            if (pause_p) begin
              state_reg <= RUN;
              running   <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_count_game_ctrl.sv
// Scoreboard bench for count_game_ctrl: a cycle-level reference model queues expected
// outputs each clock; a monitor pops and compares them shortly after every rising edge.
`timescale 1ns/1ps
module tb_count_game_ctrl;
  localparam int CLK_HZ    = 4;
  localparam int DB_CYCLES = 3;
  localparam int START_VAL = 6;
`ifdef DEBOUNCE_EN
  localparam bit DB_ON = 1'b1;
`else
  localparam bit DB_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_start = 1'b0;
  logic       btn_pause = 1'b0;
  logic [2:0] num;
  logic       running, done, tick;

  logic       btn_start0 = 1'b0;
  logic       btn_pause0 = 1'b0;
  logic [2:0] num0;
  logic       running0, done0, tick0;
  logic       tick0_seen = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  count_game_ctrl #(.CLK_HZ(CLK_HZ), .DB_CYCLES(DB_CYCLES), .START_VAL(START_VAL)) dut (
    .clk(clk), .rst_n(rst_n), .btn_start(btn_start), .btn_pause(btn_pause),
    .num(num), .running(running), .done(done), .tick(tick)
  );

  count_game_ctrl #(.CLK_HZ(CLK_HZ), .DB_CYCLES(DB_CYCLES), .START_VAL(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .btn_start(btn_start0), .btn_pause(btn_pause0),
    .num(num0), .running(running0), .done(done0), .tick(tick0)
  );

  always @(posedge clk) if (tick0) tick0_seen <= 1'b1;

  typedef struct packed {
    logic [2:0] num;
    logic       running;
    logic       done;
    logic       tick;
  } obs_t;
  obs_t exp_q[$];

  // Reference model: button history windows decide when a press is recognised;
  // the countdown tracks cycles remaining in the current second.
  typedef enum {M_IDLE, M_RUN, M_PAUSE, M_DONE} mstate_t;
  mstate_t m_state = M_IDLE;
  int      m_num = START_VAL;
  int      m_left = CLK_HZ;
  bit      m_tick, sp, pp, win_ok;
  bit      r_h [2][8];
  bit      f_h [2][8];
  bit      z_h [2][8];

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int b = 0; b < 2; b++)
        for (int k = 0; k < 8; k++) begin
          r_h[b][k] = 1'b0;
          f_h[b][k] = 1'b0;
          z_h[b][k] = 1'b0;
        end
      m_state = M_IDLE;
      m_num   = START_VAL;
      m_left  = CLK_HZ;
      exp_q.push_back(obs_t'{3'(START_VAL), 1'b0, 1'b0, 1'b0});
    end else begin
      for (int b = 0; b < 2; b++) begin
        for (int k = 7; k > 0; k--) begin
          r_h[b][k] = r_h[b][k-1];
          f_h[b][k] = f_h[b][k-1];
          z_h[b][k] = z_h[b][k-1];
        end
        r_h[b][0] = (b == 0) ? btn_start : btn_pause;
        z_h[b][0] = z_h[b][1] | ~r_h[b][0];
        if (DB_ON) begin
          win_ok = 1'b1;
          for (int k = 3; k <= DB_CYCLES + 1; k++)
            if (r_h[b][k] != r_h[b][2]) win_ok = 1'b0;
          f_h[b][0] = win_ok ? r_h[b][2] : f_h[b][1];
        end else begin
          f_h[b][0] = r_h[b][1];
        end
      end
      sp = f_h[0][2] & ~f_h[0][3] & z_h[0][4];
      pp = f_h[1][2] & ~f_h[1][3] & z_h[1][4];
      m_tick = 1'b0;
      if (sp) begin
        m_state = M_RUN;
        m_num   = START_VAL;
        m_left  = CLK_HZ;
      end else if (m_state == M_RUN && pp) begin
        m_state = M_PAUSE;
      end else if (m_state == M_PAUSE && pp) begin
        m_state = M_RUN;
      end else if (m_state == M_RUN) begin
        m_left = m_left - 1;
        if (m_left == 0) begin
          m_tick = 1'b1;
          m_num  = m_num - 1;
          m_left = CLK_HZ;
          if (m_num == 0) m_state = M_DONE;
        end
      end
      exp_q.push_back(obs_t'{3'(m_num), m_state == M_RUN, m_state == M_DONE, m_tick});
    end
  end

  obs_t got, want;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_empty t=%0t: got num=%0d with no expected entry", $time, num);
      end else begin
        want = exp_q.pop_front();
        got  = {num, running, done, tick};
        if (got !== want) begin
          errors++;
          $display("FAIL status t=%0t: got num=%0d run=%b done=%b tick=%b, required num=%0d run=%b done=%b tick=%b",
                   $time, got.num, got.running, got.done, got.tick,
                   want.num, want.running, want.done, want.tick);
        end
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input bit s, input bit p, input int len, input string tag);
    @(negedge clk);
    btn_start = s;
    btn_pause = p;
    cycles(len);
    btn_start = 1'b0;
    btn_pause = 1'b0;
    $display("txn %s start=%b pause=%b len=%0d t=%0t", tag, s, p, len, $time);
  endtask

  bit found;
  initial begin
    cycles(3);
    rst_n = 1'b1;
    cycles(20);

    checks++;
    if (num0 !== 3'd0 || done0 !== 1'b0 || running0 !== 1'b0) begin
      errors++;
      $display("FAIL sv0_reset: got num=%0d done=%b run=%b, required num=0 done=0 run=0", num0, done0, running0);
    end

    press(1'b1, 1'b0, 2, "glitch_start");
    cycles(12);
    press(1'b1, 1'b0, 5, "start");
    cycles(60);
    press(1'b1, 1'b0, 5, "start_in_done");
    cycles(8);
    press(1'b0, 1'b1, 4, "pause");
    cycles(30);
    press(1'b0, 1'b1, 4, "resume");
    cycles(40);

    for (int it = 0; it < 200; it++) begin
      int kind, len;
      kind = $urandom_range(0, 5);
      len  = $urandom_range(1, 8);
      case (kind)
        0:       press(1'b1, 1'b0, len, "rnd_start");
        1, 2:    press(1'b0, 1'b1, len, "rnd_pause");
        3:       press(1'b1, 1'b1, len, "rnd_both");
        default: cycles(len);
      endcase
      cycles($urandom_range(1, 12));
    end

    // Asynchronous reset in the middle of a countdown.
    press(1'b1, 1'b0, 5, "start_for_reset");
    found = 1'b0;
    for (int i = 0; i < 80 && !found; i++) begin
      @(negedge clk);
      if (num == 3'd3) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL wait_num3: got num=%0d, required 3 within 80 cycles", num);
    end
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (num !== 3'd6 || running !== 1'b0 || done !== 1'b0 || tick !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got num=%0d run=%b done=%b tick=%b, required num=6 run=0 done=0 tick=0",
               num, running, done, tick);
    end
    cycles(2);
    rst_n = 1'b1;
    cycles(6);

    press(1'b1, 1'b1, 5, "both_in_idle");
    cycles(20);

    // Start held across reset release must not register until pressed again.
    @(negedge clk);
    btn_start = 1'b1;
    cycles(6);
    rst_n = 1'b0;
    cycles(3);
    rst_n = 1'b1;
    cycles(12);
    btn_start = 1'b0;
    cycles(12);
    press(1'b1, 1'b0, 5, "start_after_held");
    cycles(20);

    @(negedge clk);
    btn_start0 = 1'b1;
    cycles(6);
    btn_start0 = 1'b0;
    cycles(10);
    checks++;
    if (done0 !== 1'b1 || num0 !== 3'd0 || running0 !== 1'b0) begin
      errors++;
      $display("FAIL sv0_done: got num=%0d done=%b run=%b, required num=0 done=1 run=0", num0, done0, running0);
    end
    checks++;
    if (tick0_seen !== 1'b0) begin
      errors++;
      $display("FAIL sv0_tick: got tick seen=%b, required 0", tick0_seen);
    end

    cycles(3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
